hamming_encode: RTL and testbench
=================================

Name: hamming_encode

Overview:
- Single-error-correcting Hamming parity generator for a DATA_WIDTH-bit word.
- Registered, one-cycle latency, fully pipelined (one word per cycle).
- Used by the serializer (HAS_ECC=1): it captures parity_bits_o when valid_out_o is high and shifts the parity bits out after the data bits.

Parameters:
- DATA_WIDTH, 8, payload width in bits; legal range ≥2.
- CODE_BITS (derived localparam, not overridable), smallest r with 2^r ≥ DATA_WIDTH + r + 1; equals 4 for DATA_WIDTH=8. CODED_WIDTH = DATA_WIDTH + CODE_BITS.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- data_in_i  input  DATA_WIDTH  payload word to encode.
- valid_in_i  input  1  data_in_i is valid this cycle.
- data_out_o  output  DATA_WIDTH  registered copy of the encoded payload.
- parity_bits_o  output  CODE_BITS  registered Hamming parity bits.
- valid_out_o  output  1  data_out_o and parity_bits_o are valid this cycle.

Interface rules:
- One clock; reset is asynchronous and active-high.
- No ready/backpressure. Every valid_in_i beat is accepted.

Behaviour:
- Codeword model: positions are 1-indexed, 1..CODED_WIDTH.
  - Power-of-two positions (1, 2, 4, …) hold parity bits.
  - Data bits fill the remaining positions in ascending order, data_in_i[0] at the lowest (position 3).
  - For DATA_WIDTH=8: d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
- parity_bits_o[k] is the XOR (even parity) of all data bits whose position has bit k set. For DATA_WIDTH=8:
  - p0 = d0^d1^d3^d4^d6
  - p1 = d0^d2^d3^d5^d6
  - p2 = d1^d2^d3^d7
  - p3 = d4^d5^d6^d7
- Parity is computed combinationally from data_in_i. The mapping is generated from DATA_WIDTH in loops, not hard-coded.
- Edge with valid_in_i=1:
  - data_out_o <= data_in_i, parity_bits_o <= computed parity, valid_out_o <= 1.
  - Latency is exactly 1 cycle.
- Edge with valid_in_i=0:
  - valid_out_o <= 0.
  - data_out_o and parity_bits_o hold their previous values.
- Back-to-back valid beats give back-to-back valid_out_o pulses in the same order. No throughput loss, no internal buffering beyond one register stage.
- Reset:
  - Asserting rst_i immediately (asynchronously) clears data_out_o, parity_bits_o and valid_out_o to 0.
  - They stay 0 while rst_i is high.
  - A valid_in_i beat coincident with reset is dropped.
  - The first accepted beat is the first rising edge with rst_i low and valid_in_i high.
- Mid-stream reset: a pending valid_out_o is cleared and is not regenerated after reset.
- X on data_in_i while valid_in_i=0 must not propagate to the outputs.

Test Plan:
- Reset: hold rst_i=1 with valid_in_i=1, data 0xFF -> outputs stay 0, valid_out_o=0. Release, no valid -> outputs remain 0.
- Single-bit words, DATA_WIDTH=8, one per cycle:
  - 0x01 -> parity 4'b0011
  - 0x80 -> 4'b1100
  - 0x10 -> 4'b1001
  - Each is valid exactly one cycle after its input, with data_out_o equal to the input.
- Multi-bit words:
  - 0x00 -> 4'b0000
  - 0xFF -> 4'b0011
  - 0x0F -> 4'b0111
  - 0xA5 -> 4'b0011
- Back-to-back 0x0F, 0x80, 0x00 on consecutive cycles -> valid_out_o high 3 consecutive cycles with parity 0111, 1100, 0000. Then valid drops, and outputs hold 0x00/0000 with valid_out_o=0.
- Async reset between clock edges while valid_out_o=1 (data 0xFF) -> all outputs go to 0 before the next edge.
- Exhaustive DATA_WIDTH=8: all 256 words checked against a reference encoder. Also DATA_WIDTH=4: CODE_BITS=3, input 0xF -> parity 3'b111.

Source files
------------

// File: rtl/hamming_encode.sv
// Hamming parity generator: registers a payload word together with its
// single-error-correcting parity bits, one word per cycle, one cycle latency.
module hamming_encode #(
  parameter  int unsigned DATA_WIDTH = 8,
  // Smallest r with 2^r >= DATA_WIDTH + r + 1. With s = clog2(DATA_WIDTH+1),
  // the answer is either s or s+1, and clog2(DATA_WIDTH+s+1) selects between them.
  localparam int unsigned CODE_BITS  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  valid_in_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic [CODE_BITS-1:0]  parity_bits_o,
  output logic                  valid_out_o
);

  localparam int unsigned CODED_WIDTH = DATA_WIDTH + CODE_BITS;

  // Set of payload bits covered by parity bit k. Codeword positions are
  // 1-based; powers of two are reserved for parity and data fills the rest
  // in ascending order, so data bit idx sits at the idx-th non-power position.
  function automatic logic [DATA_WIDTH-1:0] cover_mask(input int unsigned k);
    logic [DATA_WIDTH-1:0] m;
    int unsigned           idx;
    m   = '0;
    idx = 0;
    for (int unsigned pos = 1; pos <= CODED_WIDTH; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (((pos >> k) & 1) != 0) begin
          m = m | (DATA_WIDTH'(1) << idx);
        end
        idx++;
      end
    end
    return m;
  endfunction

  logic [CODE_BITS-1:0]  parity_calc;
  logic [DATA_WIDTH-1:0] data_d,   data_q;
  logic [CODE_BITS-1:0]  parity_d, parity_q;
  logic                  valid_d,  valid_q;

  // Even parity over the data bits whose codeword position has bit k set.
  for (genvar k = 0; k < CODE_BITS; k++) begin : g_parity
    localparam logic [DATA_WIDTH-1:0] MASK = cover_mask(k);
    assign parity_calc[k] = ^(data_in_i & MASK);
  end

  // Next state: capture on a valid beat, otherwise hold so an idle (possibly X) input never reaches the outputs.
  always_comb begin
    data_d   = data_q;
    parity_d = parity_q;
    valid_d  = valid_in_i;
    if (valid_in_i) begin
      data_d   = data_in_i;
      parity_d = parity_calc;
    end
  end

  // Output register stage with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q   <= '0;
      parity_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      data_q   <= data_d;
      parity_q <= parity_d;
      valid_q  <= valid_d;
    end
  end

  assign data_out_o    = data_q;
  assign parity_bits_o = parity_q;
  assign valid_out_o   = valid_q;

endmodule

// File: tb/tb_hamming_encode.sv
// Self-checking bench for hamming_encode (DATA_WIDTH=8 main instance,
// DATA_WIDTH=4 secondary instance).
module tb_hamming_encode;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       vin;
  logic [7:0] dout;
  logic [3:0] par;
  logic       vout;

  logic [3:0] din4;
  logic       vin4;
  logic [3:0] dout4;
  logic [2:0] par4;
  logic       vout4;

  always #5 clk = ~clk;

  hamming_encode #(.DATA_WIDTH(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_in_i    (din),
    .valid_in_i   (vin),
    .data_out_o   (dout),
    .parity_bits_o(par),
    .valid_out_o  (vout)
  );

  hamming_encode #(.DATA_WIDTH(4)) dut4 (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_in_i    (din4),
    .valid_in_i   (vin4),
    .data_out_o   (dout4),
    .parity_bits_o(par4),
    .valid_out_o  (vout4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder: build the codeword explicitly, then XOR every
  // position whose index has bit k set.
  function automatic logic [31:0] ref_parity(input int w, input logic [31:0] d);
    logic [63:0] code;
    logic [31:0] p;
    int          pos, idx, r;
    code = '0;
    idx  = 0;
    pos  = 1;
    while (idx < w) begin
      if ((pos & (pos - 1)) != 0) begin
        code = code | (64'((d >> idx) & 32'd1) << pos);
        idx++;
      end
      pos++;
    end
    r = 1;
    while ((1 << r) < w + r + 1) r++;
    p = '0;
    for (int k = 0; k < r; k++)
      for (int q = 1; q < pos; q++)
        if (((q >> k) & 1) != 0)
          p = p ^ (32'((code >> q) & 64'd1) << k);
    return p;
  endfunction

  // Behavioural expectation of the main instance's registered outputs.
  logic        m_valid;
  logic [7:0]  m_data;
  logic [31:0] m_par;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_par   = '0;
    end else begin
      m_valid = vin;
      if (vin) begin
        m_data = din;
        m_par  = ref_parity(8, 32'(din));
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_valid",  32'(vout), 32'(m_valid));
      chk("cyc_data",   32'(dout), 32'(m_data));
      chk("cyc_parity", 32'(par),  m_par);
    end
  end

  task automatic step(input logic v, input logic [7:0] d);
    vin = v;
    din = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] lit_w [7] = '{8'h01, 8'h80, 8'h10, 8'h00, 8'hFF, 8'h0F, 8'hA5};
  logic [3:0] lit_p [7] = '{4'b0011, 4'b1100, 4'b1001, 4'b0000, 4'b0011, 4'b0111, 4'b0011};
  logic [7:0] b2b_w [3] = '{8'h0F, 8'h80, 8'h00};
  logic [3:0] b2b_p [3] = '{4'b0111, 4'b1100, 4'b0000};

  initial begin
    rst  = 1'b1;
    vin  = 1'b1;
    din  = 8'hFF;
    vin4 = 1'b0;
    din4 = '0;
    #1 checking = 1'b1;

    // Reset held with a valid beat present: nothing captured.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  32'(vout), 32'd0);
    chk("rst_data",   32'(dout), 32'd0);
    chk("rst_parity", 32'(par),  32'd0);
    #1;
    rst = 1'b0;
    vin = 1'b0;
    din = 'x;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(vout), 32'd0);
    chk("post_rst_data",  32'(dout), 32'd0);

    // Hand-computed words, one per cycle.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, lit_w[i]);
      chk("lit_parity", 32'(par),  32'(lit_p[i]));
      chk("lit_data",   32'(dout), 32'(lit_w[i]));
      chk("lit_valid",  32'(vout), 32'd1);
      chk("model_pin",  ref_parity(8, 32'(lit_w[i])), 32'(lit_p[i]));
    end

    // Back-to-back beats then idle with X on the data bus.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, b2b_w[i]);
      chk("b2b_valid",  32'(vout), 32'd1);
      chk("b2b_parity", 32'(par),  32'(b2b_p[i]));
    end
    step(1'b0, 'x);
    step(1'b0, 'x);
    chk("hold_valid",  32'(vout), 32'd0);
    chk("hold_data",   32'(dout), 32'h00);
    chk("hold_parity", 32'(par),  32'd0);

    // Asynchronous reset between edges while output is valid.
    step(1'b1, 8'hFF);
    chk("pre_arst_valid", 32'(vout), 32'd1);
    vin = 1'b0;
    din = 'x;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid",  32'(vout), 32'd0);
    chk("arst_data",   32'(dout), 32'd0);
    chk("arst_parity", 32'(par),  32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_no_regen", 32'(vout), 32'd0);

    // Random traffic with gaps.
    repeat (300) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      step(v, v ? 8'($urandom) : 8'hxx);
    end

    // Exhaustive sweep, back-to-back.
    for (int i = 0; i < 256; i++) step(1'b1, 8'(i));
    step(1'b0, 'x);

    // Narrow instance.
    for (int i = 0; i < 16; i++) begin
      vin4 = 1'b1;
      din4 = 4'(i);
      @(posedge clk);
      #1;
      chk("w4_parity", 32'(par4),  ref_parity(4, 32'(i)));
      chk("w4_data",   32'(dout4), 32'(i));
      chk("w4_valid",  32'(vout4), 32'd1);
      if (i == 15) chk("w4_lit_F", 32'(par4), 32'b111);
    end
    vin4 = 1'b0;
    @(posedge clk);
    #1;
    chk("w4_idle_valid", 32'(vout4), 32'd0);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
